txtnt_bus_arb: RTL and testbench

Two-port bus master/arbiter that shares the TxtNtModW register bus (addr, data, OE, WR, OK) between two requesters, e.g. a host/debug port and a PWM/text sequencer. It replaces the constant-zero bus tie-off in the top level. It serialises accesses with round-robin priority, drives one bus transaction at a time, waits for the slave's OK, returns read data and acknowledges the winner.

---
 rtl/txtnt_bus_pkg.sv | 15 +
 rtl/txtnt_rr_pick.sv | 22 ++
 rtl/txtnt_bus_arb.sv | 172 +++++++++++++++++
 tb/tb_txtnt_bus_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/txtnt_bus_pkg.sv
// Shared types and defaults for the TxtNtModW bus arbiter.
// State encoding, bus widths and default timeout.
package txtnt_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } busState_e;

  localparam int TXTNT_ADDR_W      = 32;
  localparam int TXTNT_DATA_W      = 32;
  localparam int TXTNT_TIMEOUT_DEF = 255;

endpackage

// File: rtl/txtnt_rr_pick.sv
// Two-way combinational round-robin picker.
// On a tie, the port that did not win last time is chosen.
module txtnt_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gntValid,
  output logic gntIdx
);

  // pick the winner from the request pair and the previous winner
  always_comb begin
    gntValid = req0 | req1;
    gntIdx   = 1'b0;
    unique case (1'b1)
      req0 & req1:  gntIdx = ~last;
      req1 & ~req0: gntIdx = 1'b1;
      default:      gntIdx = 1'b0;
    endcase
  end

endmodule

// File: rtl/txtnt_bus_arb.sv
// Two-port round-robin master for the TxtNtModW register bus.
// Optional access timeout: define TXTNT_BUSARB_TIMEOUT_EN.
module txtnt_bus_arb
  import txtnt_bus_pkg::*;
#(
  parameter int ADDR_W         = TXTNT_ADDR_W,
  parameter int DATA_W         = TXTNT_DATA_W,
  parameter int TIMEOUT_CYCLES = TXTNT_TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] busAddr,
  output logic [DATA_W-1:0] busDataOut,
  input  logic [DATA_W-1:0] busDataIn,
  output logic              busOE,
  output logic              busWR,
  input  logic              busOK
);

  busState_e state, stateNxt;

  logic last, lastNxt;
  logic gnt, gntNxt;
  logic pickValid, pickIdx;
  logic selWr;

  logic [ADDR_W-1:0] addrNxt;
  logic [DATA_W-1:0] doutNxt;
  logic [DATA_W-1:0] rdataNxt;
  logic oeNxt, wrNxt;
  logic ack0Nxt, ack1Nxt;
  logic err0Nxt, err1Nxt;

`ifdef TXTNT_BUSARB_TIMEOUT_EN
  localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = (CLOG > 8) ? CLOG : 8;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic timeout;
  assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYCLES;
`endif

  txtnt_rr_pick uPick (
    .req0     (req0),
    .req1     (req1),
    .last     (last),
    .gntValid (pickValid),
    .gntIdx   (pickIdx)
  );

  assign selWr = pickIdx ? wr1 : wr0;

  // state register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= stateNxt;
  end

  // next state, bus strobes, acks and read data
  always_comb begin
    stateNxt = state;
    lastNxt  = last;
    gntNxt   = gnt;
    addrNxt  = busAddr;
    doutNxt  = busDataOut;
    oeNxt    = busOE;
    wrNxt    = busWR;
    rdataNxt = rdata;
    ack0Nxt  = 1'b0;
    ack1Nxt  = 1'b0;
    err0Nxt  = 1'b0;
    err1Nxt  = 1'b0;
`ifdef TXTNT_BUSARB_TIMEOUT_EN
    cntNxt   = cnt;
`endif
    unique case (state)
      IDLE: begin
        if (pickValid) begin
          stateNxt = ACCESS;
          lastNxt  = pickIdx;
          gntNxt   = pickIdx;
          addrNxt  = pickIdx ? addr1 : addr0;
          doutNxt  = pickIdx ? wdata1 : wdata0;
          wrNxt    = selWr;
          oeNxt    = ~selWr;
`ifdef TXTNT_BUSARB_TIMEOUT_EN
          cntNxt   = '0;
`endif
        end
      end
      ACCESS: begin
        if (busOK) begin
          stateNxt = RELEASE;
          oeNxt    = 1'b0;
          wrNxt    = 1'b0;
          ack0Nxt  = ~gnt;
          ack1Nxt  = gnt;
          if (busOE) rdataNxt = busDataIn;
        end
`ifdef TXTNT_BUSARB_TIMEOUT_EN
        else if (timeout) begin
          stateNxt = RELEASE;
          oeNxt    = 1'b0;
          wrNxt    = 1'b0;
          ack0Nxt  = ~gnt;
          ack1Nxt  = gnt;
          err0Nxt  = ~gnt;
          err1Nxt  = gnt;
          rdataNxt = '0;
        end else begin
          cntNxt = cnt + CNT_W'(1);
        end
`endif
      end
      RELEASE: stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // registered bus and requester outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      last       <= 1'b1;
      gnt        <= 1'b0;
      busAddr    <= '0;
      busDataOut <= '0;
      busOE      <= 1'b0;
      busWR      <= 1'b0;
      rdata      <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      last       <= lastNxt;
      gnt        <= gntNxt;
      busAddr    <= addrNxt;
      busDataOut <= doutNxt;
      busOE      <= oeNxt;
      busWR      <= wrNxt;
      rdata      <= rdataNxt;
      ack0       <= ack0Nxt;
      ack1       <= ack1Nxt;
      err0       <= err0Nxt;
      err1       <= err1Nxt;
    end
  end

`ifdef TXTNT_BUSARB_TIMEOUT_EN
  // access watchdog counter
  always_ff @(posedge clock) begin
    if (!reset) cnt <= '0;
    else        cnt <= cntNxt;
  end
`endif

endmodule

// File: tb/tb_txtnt_bus_arb.sv
// Bench for txtnt_bus_arb: directed and random transactions
// checked against a transaction-level round-robin model.
module tb_txtnt_bus_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, wr0, wr1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata, busAddr, busDataOut, busDataIn;
  logic        busOE, busWR, busOK;

  int checks   = 0;
  int failures = 0;

  // model state: previous winner and expected read-data register
  int          lastW;
  logic [31:0] rdataExp;

  always #5 clock = ~clock;

  txtnt_bus_arb #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .wr0        (wr0),
    .wr1        (wr1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .ack0       (ack0),
    .ack1       (ack1),
    .err0       (err0),
    .err1       (err1),
    .rdata      (rdata),
    .busAddr    (busAddr),
    .busDataOut (busDataOut),
    .busDataIn  (busDataIn),
    .busOE      (busOE),
    .busWR      (busWR),
    .busOK      (busOK)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, ".addr"}, busAddr, 0);
    check({tag, ".dout"}, busDataOut, 0);
    check({tag, ".strb"}, {busOE, busWR}, 0);
    check({tag, ".ack"}, {ack0, ack1}, 0);
    check({tag, ".err"}, {err0, err1}, 0);
    check({tag, ".rdata"}, rdata, 0);
  endtask

  // One bus transaction: expects a grant on the next edge, lets the
  // slave wait dly cycles, then returns d and checks the ack cycle.
  task automatic doAccess(input int dly, input bit drop,
                          input logic [31:0] d, output int who);
    int          n;
    logic [31:0] eA, eD;
    logic        eW;
    n = 0;
    while (!(busOE || busWR) && n < 6) begin
      tick();
      n++;
    end
    check("grantLat", n, 1);
    if (req0 && req1) who = (lastW == 1) ? 0 : 1;
    else              who = req1 ? 1 : 0;
    lastW = who;
    eA = (who == 1) ? addr1 : addr0;
    eD = (who == 1) ? wdata1 : wdata0;
    eW = (who == 1) ? wr1 : wr0;
    check("grantAddr", busAddr, eA);
    check("grantData", busDataOut, eD);
    check("grantStrb", {busOE, busWR}, {~eW, eW});
    if (who == 1) begin
      addr1 = $urandom; wdata1 = $urandom; wr1 = ~wr1;
    end else begin
      addr0 = $urandom; wdata0 = $urandom; wr0 = ~wr0;
    end
    for (int i = 0; i < dly; i++) begin
      tick();
      check("waitAddr", busAddr, eA);
      check("waitData", busDataOut, eD);
      check("waitStrb", {busOE, busWR}, {~eW, eW});
      check("waitAck", {ack0, ack1}, 0);
    end
    busDataIn = d;
    busOK = 1'b1;
    tick();
    busOK = 1'b0;
    busDataIn = $urandom;
    if (!eW) rdataExp = d;
    check("ack0", ack0, (who == 0));
    check("ack1", ack1, (who == 1));
    check("ackErr", {err0, err1}, 0);
    check("ackStrb", {busOE, busWR}, 0);
    check("ackRdata", rdata, rdataExp);
    if (drop) begin
      if (who == 1) req1 = 1'b0;
      else          req0 = 1'b0;
    end
    tick();
    check("relAck", {ack0, ack1}, 0);
    check("relStrb", {busOE, busWR}, 0);
  endtask

  initial begin
    int who;
    int n;
    int cnt;
    bit sawAck;

    reset = 1'b0;
    {req0, req1, wr0, wr1, busOK} = '0;
    {addr0, addr1, wdata0, wdata1, busDataIn} = '0;
    lastW = 1;
    rdataExp = '0;
    tick();
    tick();
    checkIdle("reset");
    reset = 1'b1;
    tick();

    // stray busOK while idle must do nothing
    busOK = 1'b1;
    tick();
    busOK = 1'b0;
    checkIdle("strayOK");
    tick();

    // single read from 0x10
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10; wdata0 = 32'h0;
    doAccess(0, 1'b1, 32'hDEADBEEF, who);
    check("singleRdata", rdata, 32'hDEADBEEF);

    // simultaneous requests: both served, each dropped after ack
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h1111;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h30; wdata1 = 32'h2222;
    doAccess(1, 1'b1, 32'hA5A5A5A5, who);
    doAccess(0, 1'b1, 32'h5A5A5A5A, who);

    // slave wait of 5 cycles on a write
    req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h4; wdata1 = 32'hFF;
    doAccess(5, 1'b1, 32'h12345678, who);

    // fairness: both held for six transactions
    req0 = 1'b1; wr0 = 1'b0; addr0 = $urandom; wdata0 = $urandom;
    req1 = 1'b1; wr1 = 1'b1; addr1 = $urandom; wdata1 = $urandom;
    for (int i = 0; i < 6; i++)
      doAccess($urandom_range(0, 2), 1'b0, $urandom, who);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();

    // random traffic
    for (int i = 0; i < 24; i++) begin
      if (!req0 && $urandom_range(0, 1) == 1) begin
        req0 = 1'b1; wr0 = 1'($urandom);
        addr0 = $urandom; wdata0 = $urandom;
      end
      if (!req1 && $urandom_range(0, 1) == 1) begin
        req1 = 1'b1; wr1 = 1'($urandom);
        addr1 = $urandom; wdata1 = $urandom;
      end
      if (!req0 && !req1) begin
        req1 = 1'b1; wr1 = 1'($urandom);
        addr1 = $urandom; wdata1 = $urandom;
      end
      doAccess($urandom_range(0, 3), 1'b1, $urandom, who);
    end
    while (req0 || req1)
      doAccess($urandom_range(0, 3), 1'b1, $urandom, who);
    tick();

    // slave never answers a read from port 1
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h40; wdata1 = 32'h0;
    n = 0;
    while (!(busOE || busWR) && n < 6) begin
      tick();
      n++;
    end
    check("toGrantLat", n, 1);
    lastW = 1;
`ifdef TXTNT_BUSARB_TIMEOUT_EN
    cnt = 1;
    n = 0;
    while (!ack1 && n < 40) begin
      tick();
      n++;
      if (!ack1 && busOE) cnt++;
    end
    rdataExp = '0;
    check("toCycles", cnt, 8);
    check("toAck", {ack0, ack1}, 2'b01);
    check("toErr", {err0, err1}, 2'b01);
    check("toRdata", rdata, 0);
    check("toStrb", {busOE, busWR}, 0);
    req1 = 1'b0;
    tick();
    check("toRel", {ack0, ack1, err0, err1, busOE, busWR}, 0);
`else
    sawAck = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ack1 || ack0) sawAck = 1'b1;
    end
    check("stillWaiting", {sawAck, busOE}, 2'b01);
    check("stillAddr", busAddr, 32'h40);
    reset = 1'b0;
    req1 = 1'b0;
    tick();
    reset = 1'b1;
    lastW = 1;
    rdataExp = '0;
    checkIdle("noToReset");
`endif
    tick();

    // reset during a waiting write, then a normal read
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h88; wdata0 = 32'hCAFE;
    tick();
    check("rstGrant", busWR, 1);
    tick();
    tick();
    reset = 1'b0;
    req0 = 1'b0;
    tick();
    checkIdle("midReset");
    reset = 1'b1;
    lastW = 1;
    rdataExp = '0;
    tick();
    check("postRstAck", {ack0, ack1, busOE, busWR}, 0);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h8C;
    doAccess(2, 1'b1, 32'h0BADF00D, who);
    check("postRstRdata", rdata, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
